// File: rtl/pool_lii_arbiter_pkg.sv
// Shared definitions for the LII pool arbiter: ID width, default packing
// width and the arbiter state encoding.
package pool_lii_arbiter_pkg;

  localparam int LII_ID_W       = 8;
  localparam int LII_PW_DEFAULT = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/pool_lii_arbiter_rr_pick.sv
// Circular first-one picker: returns the first set bit of req, scanning
// upward from rr_ptr and wrapping at N.
module lii_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] grant,
  output logic          any_valid
);

  logic [IW-1:0] idx;

  // Scan N positions starting at rr_ptr and keep the first requester seen.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

endmodule

// File: rtl/pool_lii_arbiter.sv
// Round-robin packet arbiter: N requester streams share one LII phy output
// through a single-entry output register, with a per-grant beat limit.
module pool_lii_arbiter
  import pool_lii_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int PW        = LII_PW_DEFAULT,
  parameter int SRC_BASE  = 0,
  parameter int MAX_BEATS = 16,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [N*PW-1:0]        req_tdata,
  input  logic [N-1:0]           req_tvalid,
  output logic [N-1:0]           req_tready,
  input  logic [N-1:0]           req_tlast,
  input  logic [N*LII_ID_W-1:0]  req_dst,
  output logic [PW-1:0]          lii_out_p0_tdata,
  output logic                   lii_out_p0_tvalid,
  input  logic                   lii_out_p0_tready,
  output logic                   lii_out_p0_tlast,
  output logic [LII_ID_W-1:0]    lii_out_p0_src,
  output logic [LII_ID_W-1:0]    lii_out_p0_dst,
  output logic [IW-1:0]          grant_idx,
  output logic                   busy
);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [PW-1:0]       out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [LII_ID_W-1:0] out_src_q, out_src_d;
  logic [LII_ID_W-1:0] out_dst_q, out_dst_d;

  logic [IW-1:0]       pick_grant;
  logic                pick_any;
  logic                is_busy;
  logic                out_ready;
  logic                accept;
  logic                sel_valid;
  logic                sel_last;
  logic [PW-1:0]       sel_data;
  logic [LII_ID_W-1:0] sel_dst;
  logic [CW-1:0]       cnt_inc;
  logic                hit_max;

  lii_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req       (req_tvalid),
    .rr_ptr    (rr_q),
    .grant     (pick_grant),
    .any_valid (pick_any)
  );

  // The output register can take a new beat when empty or being drained.
  assign is_busy   = (state_q == ST_BUSY);
  assign out_ready = ~out_valid_q | lii_out_p0_tready;
  assign sel_valid = req_tvalid[grant_q];
  assign sel_last  = req_tlast[grant_q];
  assign sel_data  = req_tdata[int'(grant_q)*PW +: PW];
  assign sel_dst   = req_dst[int'(grant_q)*LII_ID_W +: LII_ID_W];
  assign accept    = is_busy & sel_valid & out_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  assign hit_max   = (cnt_inc == CW'(MAX_BEATS));

  // Only the current owner sees ready, and only while the output can move.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign req_tready[gi] = is_busy & out_ready & (grant_q == IW'(gi));
  end

  // Arbitration, beat counting, release and output-register next state.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    out_dst_d   = out_dst_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          grant_d = pick_grant;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          cnt_d = cnt_inc;
          // Packet end or beat limit hands the channel back; the limit
          // path leaves the rest of the packet for a later grant.
          if (sel_last || hit_max) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rr_d    = IW'((int'(grant_q) + 1) % N);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_src_d   = LII_ID_W'(SRC_BASE + int'(grant_q));
      out_dst_d   = sel_dst;
    end else if (lii_out_p0_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any grant and buffered beat.
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      out_dst_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      out_dst_q   <= out_dst_d;
    end
  end

  assign lii_out_p0_tvalid = out_valid_q;
  assign lii_out_p0_tdata  = out_data_q;
  assign lii_out_p0_tlast  = out_last_q;
  assign lii_out_p0_src    = out_src_q;
  assign lii_out_p0_dst    = out_dst_q;
  assign grant_idx         = grant_q;
  assign busy              = is_busy;

endmodule

// File: tb/tb_pool_lii_arbiter.sv
// Bench for pool_lii_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model of the arbitration rules.
module tb_pool_lii_arbiter;

  localparam int N    = 4;
  localparam int PW   = 64;
  localparam int SRCB = 0;
  localparam int MAXB = 16;
  localparam int IW   = 2;

  logic            aclk;
  logic            arst;
  logic [N*PW-1:0] req_tdata;
  logic [N-1:0]    req_tvalid;
  logic [N-1:0]    req_tready;
  logic [N-1:0]    req_tlast;
  logic [N*8-1:0]  req_dst;
  logic [PW-1:0]   lii_out_p0_tdata;
  logic            lii_out_p0_tvalid;
  logic            lii_out_p0_tready;
  logic            lii_out_p0_tlast;
  logic [7:0]      lii_out_p0_src;
  logic [7:0]      lii_out_p0_dst;
  logic [IW-1:0]   grant_idx;
  logic            busy;

  pool_lii_arbiter #(.N(N), .PW(PW), .SRC_BASE(SRCB), .MAX_BEATS(MAXB)) dut (
    .aclk              (aclk),
    .arst              (arst),
    .req_tdata         (req_tdata),
    .req_tvalid        (req_tvalid),
    .req_tready        (req_tready),
    .req_tlast         (req_tlast),
    .req_dst           (req_dst),
    .lii_out_p0_tdata  (lii_out_p0_tdata),
    .lii_out_p0_tvalid (lii_out_p0_tvalid),
    .lii_out_p0_tready (lii_out_p0_tready),
    .lii_out_p0_tlast  (lii_out_p0_tlast),
    .lii_out_p0_src    (lii_out_p0_src),
    .lii_out_p0_dst    (lii_out_p0_dst),
    .grant_idx         (grant_idx),
    .busy              (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [7:0]    dst;
    logic          last;
  } beat_t;

  typedef struct {
    int    src;
    beat_t b;
  } out_t;

  // Reference model: pending beats per requester, the one beat in flight,
  // and the ownership/rotation bookkeeping.
  beat_t src_q [N][$];
  out_t  out_q [$];
  bit    m_busy;
  int    m_g;
  int    m_rr;
  int    m_cnt;

  int take_cyc [$];
  int take_src [$];
  int take_last [$];

  int n_chk;
  int n_err;
  int cyc;
  int vprob;
  int rprob;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load_pkt(input int r, input int len, input logic [7:0] dst);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.dst  = dst;
      b.last = (k == len - 1);
      src_q[r].push_back(b);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0) return 1'b1;
    return (out_q.size() != 0) || m_busy;
  endfunction

  task automatic clear_logs();
    take_cyc.delete();
    take_src.delete();
    take_last.delete();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 && int'($urandom_range(99)) < vprob) begin
        req_tvalid[i]         = 1'b1;
        req_tdata[i*PW +: PW] = src_q[i][0].data;
        req_dst[i*8 +: 8]     = src_q[i][0].dst;
        req_tlast[i]          = src_q[i][0].last;
      end else begin
        req_tvalid[i]         = 1'b0;
        req_tdata[i*PW +: PW] = {$urandom, $urandom};
        req_dst[i*8 +: 8]     = 8'($urandom);
        req_tlast[i]          = 1'($urandom);
      end
    end
    lii_out_p0_tready = (int'($urandom_range(99)) < rprob);
  endtask

  // Called mid-cycle: compare the DUT against the model, then advance the
  // model by what the coming clock edge will do.
  task automatic observe();
    logic [N-1:0] exp_rdy;
    bit           out_rdy;
    bit           found;
    out_t         o;
    beat_t        b;
    if (arst) begin
      for (int i = 0; i < N; i++) src_q[i].delete();
      out_q.delete();
      m_busy = 1'b0;
      m_g    = 0;
      m_rr   = 0;
      m_cnt  = 0;
      return;
    end
    chk("busy", 64'(busy), 64'(m_busy));
    if (m_busy) chk("grant_idx", 64'(grant_idx), 64'(m_g));
    out_rdy = (out_q.size() == 0) || lii_out_p0_tready;
    exp_rdy = '0;
    if (m_busy && out_rdy) exp_rdy[m_g[IW-1:0]] = 1'b1;
    chk("req_tready", 64'(req_tready), 64'(exp_rdy));
    chk("out_tvalid", 64'(lii_out_p0_tvalid), 64'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      o = out_q[0];
      chk("out_src",   64'(lii_out_p0_src),   64'(SRCB + o.src));
      chk("out_dst",   64'(lii_out_p0_dst),   64'(o.b.dst));
      chk("out_tlast", 64'(lii_out_p0_tlast), 64'(o.b.last));
      chk("out_tdata", lii_out_p0_tdata, o.b.data);
      if (lii_out_p0_tready) begin
        $display("beat cyc=%0d src=%0d dst=%02h last=%0d data=%016h",
                 cyc, lii_out_p0_src, lii_out_p0_dst, lii_out_p0_tlast, lii_out_p0_tdata);
        take_cyc.push_back(cyc);
        take_src.push_back(o.src);
        take_last.push_back(int'(o.b.last));
        void'(out_q.pop_front());
      end
    end
    if (m_busy) begin
      if (req_tvalid[m_g[IW-1:0]] && exp_rdy[m_g[IW-1:0]]) begin
        b = src_q[m_g].pop_front();
        out_q.push_back('{src: m_g, b: b});
        m_cnt++;
        if (b.last || m_cnt == MAXB) begin
          m_busy = 1'b0;
          m_cnt  = 0;
          m_rr   = (m_g + 1) % N;
        end
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        automatic int idx = (m_rr + k) % N;
        if (!found && req_tvalid[idx[IW-1:0]]) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_g    = idx;
          m_cnt  = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    observe();
    @(posedge aclk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (pending() && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(pending()), 64'(0));
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    tick();
    chk("rst_tvalid", 64'(lii_out_p0_tvalid), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_grant",  64'(grant_idx), 64'(0));
    chk("rst_tready", 64'(req_tready), 64'(0));
    chk("rst_tdata",  lii_out_p0_tdata, 64'(0));
    chk("rst_tlast",  64'(lii_out_p0_tlast), 64'(0));
    chk("rst_src",    64'(lii_out_p0_src), 64'(0));
    chk("rst_dst",    64'(lii_out_p0_dst), 64'(0));
    arst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    int total;
    int len;
    int exp_seq [10];
    arst              = 1'b1;
    req_tdata         = '0;
    req_tvalid        = '0;
    req_tlast         = '0;
    req_dst           = '0;
    lii_out_p0_tready = 1'b0;
    n_chk             = 0;
    n_err             = 0;
    cyc               = 0;
    vprob             = 100;
    rprob             = 100;
    @(posedge aclk);
    #1;

    // Single requester, 3-beat packet: latency and release timing.
    do_reset();
    clear_logs();
    load_pkt(1, 3, 8'h05);
    drive_inputs();
    c0 = cyc;
    drain(100);
    chk("t035_nbeats", 64'(take_cyc.size()), 64'(3));
    if (take_cyc.size() == 3) begin
      chk("t035_latency", 64'(take_cyc[0] - c0), 64'(2));
      chk("t035_span",    64'(take_cyc[2] - take_cyc[0]), 64'(2));
      chk("t035_last",    64'(take_last[2]), 64'(1));
      chk("t035_src",     64'(take_src[0]), 64'(1));
    end

    // All four requesters with 2-beat packets, requester 0 has a second one.
    do_reset();
    clear_logs();
    load_pkt(0, 2, 8'h10);
    load_pkt(1, 2, 8'h11);
    load_pkt(2, 2, 8'h12);
    load_pkt(3, 2, 8'h13);
    load_pkt(0, 2, 8'h14);
    drive_inputs();
    drain(200);
    exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    chk("t036_nbeats", 64'(take_src.size()), 64'(10));
    if (take_src.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("t036_order", 64'(take_src[i]), 64'(exp_seq[i]));
        if (i > 0) chk("t036_gap", 64'(take_cyc[i] - take_cyc[i-1]), 64'((i % 2 == 0) ? 2 : 1));
      end
    end

    // 20-beat packet against a 16-beat limit.
    do_reset();
    clear_logs();
    load_pkt(2, 20, 8'h22);
    drive_inputs();
    drain(200);
    chk("t037_nbeats", 64'(take_cyc.size()), 64'(20));
    if (take_cyc.size() == 20) begin
      chk("t037_last16",  64'(take_last[15]), 64'(0));
      chk("t037_bubble",  64'(take_cyc[16] - take_cyc[15]), 64'(2));
      chk("t037_last20",  64'(take_last[19]), 64'(1));
      chk("t037_src",     64'(take_src[16]), 64'(2));
    end

    // Output backpressure for 5 cycles mid-packet.
    do_reset();
    clear_logs();
    load_pkt(0, 8, 8'h38);
    drive_inputs();
    n = 0;
    while (take_cyc.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("t038_reach", 64'(take_cyc.size() >= 3), 64'(1));
    rprob             = 0;
    lii_out_p0_tready = 1'b0;
    repeat (4) tick();
    rprob = 100;
    drain(100);
    chk("t038_nbeats", 64'(take_cyc.size()), 64'(8));
    if (take_cyc.size() == 8)
      chk("t038_stall", 64'(take_cyc[3] - take_cyc[2]), 64'(6));

    // Reset during beat 2 of 4, then 0 and 3 compete with the pointer at 0.
    clear_logs();
    load_pkt(0, 4, 8'h39);
    drive_inputs();
    n = 0;
    while (src_q[0].size() > 3 && n < 20) begin
      tick();
      n++;
    end
    chk("t039_reach", 64'(src_q[0].size()), 64'(3));
    arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("t039_tvalid", 64'(lii_out_p0_tvalid), 64'(0));
    chk("t039_busy",   64'(busy), 64'(0));
    chk("t039_tready", 64'(req_tready), 64'(0));
    tick();
    chk("t039_no_emit", 64'(lii_out_p0_tvalid), 64'(0));
    clear_logs();
    load_pkt(3, 2, 8'h3a);
    load_pkt(0, 2, 8'h3b);
    drive_inputs();
    drain(100);
    chk("t039_nbeats", 64'(take_src.size()), 64'(4));
    if (take_src.size() == 4) begin
      chk("t039_first", 64'(take_src[0]), 64'(0));
      chk("t039_second", 64'(take_src[2]), 64'(3));
    end

    // Random traffic with random valid gaps and backpressure.
    do_reset();
    clear_logs();
    vprob = 70;
    rprob = 70;
    total = 0;
    for (int r = 0; r < N; r++) begin
      for (int p = 0; p < 3; p++) begin
        len = int'($urandom_range(20, 1));
        total += len;
        load_pkt(r, len, 8'($urandom));
      end
    end
    drive_inputs();
    drain(5000);
    chk("rand_nbeats", 64'(take_cyc.size()), 64'(total));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pool_lii_arbiter.md
POOL_LII_ARBITER -- requirements
Module: pool_lii_arbiter

Interface
REQ-001 Parameter N, default 4: number of logical requesters (kernel output streams) sharing one LII phy output channel.
REQ-002 Parameter PW, default 64: LII packing width in bits.
REQ-003 Parameter SRC_BASE, default 0: LII source ID of requester 0; requester i is tagged SRC_BASE+i.
REQ-004 Parameter MAX_BEATS, default 16: maximum beats per grant before forced release.
REQ-005 aclk  in  1  single clock, all logic rising-edge.
REQ-006 arst  in  1  reset, synchronous, active-high.
REQ-007 req_tdata  in  N*PW  requester data, requester i at [i*PW +: PW].
REQ-008 req_tvalid  in  N  requester valid.
REQ-009 req_tready  out  N  requester ready.
REQ-010 req_tlast  in  N  last beat of requester packet.
REQ-011 req_dst  in  N*8  requester destination ID, requester i at [i*8 +: 8].
REQ-012 lii_out_p0_tdata  out  PW  phy data.
REQ-013 lii_out_p0_tvalid  out  1  phy valid.
REQ-014 lii_out_p0_tready  in  1  phy ready.
REQ-015 lii_out_p0_tlast  out  1  phy last.
REQ-016 lii_out_p0_src  out  8  source ID of the current beat.
REQ-017 lii_out_p0_dst  out  8  destination ID of the current beat.
REQ-018 grant_idx  out  clog2(N)  index of current owner; busy  out  1  high in BUSY state.

Function
REQ-019 FSM states: IDLE and BUSY; arbitration takes exactly one cycle in IDLE.
REQ-020 IDLE: when any req_tvalid is high, grant SHALL go to the first valid requester scanning circularly from rr_ptr, with grant_idx registered and state BUSY in the next cycle; otherwise remain IDLE.
REQ-021 In BUSY, req_tready[i] = (i==grant_idx) & (~lii_out_p0_tvalid | lii_out_p0_tready); all other req_tready are 0; in IDLE all req_tready are 0.
REQ-022 A beat is accepted when req_tvalid[g] & req_tready[g]; it SHALL appear on the output register the next cycle (latency 1) with tdata, tlast, dst copied and src = SRC_BASE+g.
REQ-023 The output register SHALL hold its contents stable while lii_out_p0_tvalid & ~lii_out_p0_tready; tvalid clears when it is taken and no new beat is accepted in the same cycle.
REQ-024 Full-throughput: simultaneous output take and input accept SHALL sustain one beat per cycle.
REQ-025 Beat counter (width clog2(MAX_BEATS+1)) resets to 0 on each new grant and increments per accepted beat.
REQ-026 Grant SHALL be released (BUSY->IDLE) in the cycle after an accepted beat with req_tlast=1 or with counter reaching MAX_BEATS, whichever occurs first; rr_ptr := (g+1) mod N.
REQ-027 Forced release by MAX_BEATS mid-packet SHALL forward that beat with its own tlast (0); the remainder continues on the requester's next grant.
REQ-028 Granted requester deasserting tvalid mid-packet SHALL NOT release grant.
REQ-029 Release and pending requests in the same cycle: one IDLE bubble cycle, then REQ-020 applies.
REQ-030 req_tdata/req_dst of non-granted requesters SHALL have no effect on outputs.

Reset
REQ-031 On arst: state IDLE, rr_ptr 0, grant_idx 0, busy 0, counter 0, lii_out_p0_tvalid 0, tdata/tlast/src/dst 0, all req_tready 0.
REQ-032 arst mid-packet SHALL discard the output register contents and any in-flight grant; no beat is emitted after reset until a new arbitration.

Structure
REQ-033 Shared package holds LII ID width (8), the IDLE/BUSY state enum and the default PW.
REQ-034 One sub-module, lii_rr_pick: combinational circular first-one picker (req vector, rr_ptr -> grant index, any).

Verification
REQ-035 Single requester 1, 3-beat packet dst=0x05, tready=1: grant_idx=1 after 1 cycle, beats out 1 cycle after accept, src=1, dst=0x05, tlast on beat 3, then IDLE.
REQ-036 All 4 requesters valid with 2-beat packets, rr_ptr=0: output source order 0,1,2,3,0 with one IDLE bubble between packets.
REQ-037 Requester 2 sends 20-beat packet, MAX_BEATS=16, requester 3 idle: release after 16 beats with tlast=0, re-grant to 2, remaining 4 beats, tlast on beat 20.
REQ-038 lii_out_p0_tready held 0 for 5 cycles mid-packet: output data stable, req_tready[g]=0 while register full, no beat lost or duplicated after tready returns.
REQ-039 arst pulsed during beat 2 of 4: next cycle tvalid=0, busy=0, rr_ptr=0; subsequent packet from requester 0 arbitrates normally.
